fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage of the 16-bit pipeline: owns the PC, issues word fetches to
//   instruction memory and presents one instruction per cycle to decode. Consumes the
//   branch-taken decision and target produced in decode/execute, redirects the PC and
//   squashes wrong-path work.
// PARAMETERS
//   ADDR_W        16       PC / instruction memory word-address width
//   INSTR_W       16       instruction width
//   RESET_VECTOR  16'h0000 PC value loaded on reset
// PORTS
//   clk_pi              in   1        single clock, all state updates on rising edge
//   reset_pi            in   1        synchronous, active-high reset
//   branch_valid_pi     in   1        a branch instruction is resolving this cycle
//   is_branch_taken_pi  in   1        branch decision; meaningful only with branch_valid_pi
//   branch_target_pi    in   ADDR_W   redirect address; meaningful only on a taken branch
//   stall_pi            in   1        decode cannot accept; hold the current instruction
//   imem_req_po         out  1        fetch request to instruction memory
//   imem_addr_po        out  ADDR_W   fetch address; stable while imem_req_po is high
//   imem_ack_pi         in   1        one-cycle strobe; imem_rdata_pi valid this cycle
//   imem_rdata_pi       in   INSTR_W  fetched instruction word
//   instr_po            out  INSTR_W  instruction to decode
//   instr_pc_po         out  ADDR_W   address of instr_po
//   instr_valid_po      out  1        instr_po/instr_pc_po valid
//   flush_po            out  1        one-cycle pulse: decode must discard its instruction
//   fetch_count_po      out  16       fetched-instruction counter (see CONFIGURATION)
//   branch_count_po     out  16       taken-branch counter (see CONFIGURATION)
// BEHAVIOUR
//   Reset: pc=RESET_VECTOR, state=S_BOOT. All outputs 0, imem_addr_po=RESET_VECTOR.
//     Reset mid-request abandons the request; a later ack is ignored.
//   Memory handshake: request opens when imem_req_po rises with imem_addr_po and closes
//     on imem_ack_pi. Address is held stable while open. Ack may arrive in the same cycle.
//   States:
//     S_BOOT   one idle cycle after reset -> S_FETCH.
//     S_FETCH  req=1, addr=pc. On ack:
//                capture rdata -> instr_po and pc -> instr_pc_po;
//                instr_valid_po=1 next cycle;
//                pc <= pc+1, wrapping mod 2^ADDR_W (16'hFFFF -> 16'h0000).
//              If ack arrives while instr_valid_po=1 and stall_pi=1 -> S_HOLD.
//              Otherwise remain in S_FETCH.
//     S_HOLD   req=0. instr_po, instr_pc_po and instr_valid_po held. Leave when stall_pi=0.
//     S_DRAIN  req=1 at the old address until ack; the ack data is discarded -> S_FETCH.
//   Stall: instr_* is not overwritten while stall_pi=1 and instr_valid_po=1.
//     No new request is issued when the captured word has no place to go.
//   Taken branch (branch_valid_pi & is_branch_taken_pi at cycle N):
//     cycle N+1: pc=branch_target_pi, flush_po=1, instr_valid_po=0.
//     If the request was open at N and not acked at N -> S_DRAIN, else -> S_FETCH.
//     An ack at N is discarded.
//     A branch overrides stall_pi, S_HOLD and any same-cycle ack.
//     branch_valid_pi with is_branch_taken_pi=0 has no effect.
//   Latency, zero-wait memory: ack at N -> instr_valid_po at N+1.
//     Taken branch at N -> target instruction valid at N+2 at the earliest.
//   Back-to-back taken branches: the latest one wins; each produces one flush_po pulse.
// CONFIGURATION
//   Macro FETCH_PERF_CNT_EN.
//   Defined: fetch_count_po increments on every accepted (non-discarded) ack.
//     branch_count_po increments on every taken branch.
//     Both counters saturate at 16'hFFFF and are cleared by reset.
//   Undefined: both ports are present and tied to 16'h0000; no counter logic.
// STRUCTURE
//   Package fetch_pkg holds: the state enum (S_BOOT, S_FETCH, S_HOLD, S_DRAIN),
//     ADDR_W/INSTR_W defaults and the RESET_VECTOR default.
//   Sub-module fetch_perf_counters holds the two saturating counters;
//     instantiated only under FETCH_PERF_CNT_EN.
// TESTING
//   1. Reset, zero-wait ack every cycle -> instr_pc_po 0,1,2,3 on consecutive cycles;
//      first instr_valid_po two cycles after reset release.
//   2. Ack delayed 3 cycles -> imem_addr_po held constant; exactly one instruction captured.
//   3. stall_pi high for 4 cycles with instr valid -> instr_po unchanged;
//      imem_req_po=0 in S_HOLD; resumes at the next pc.
//   4. Taken branch to 16'h0040 with the request acked in the same cycle -> flush_po 1 cycle;
//      acked word dropped; next instr_pc_po=16'h0040.
//   5. Taken branch to 16'h0100 with an open unacked request -> S_DRAIN;
//      old word discarded after its ack; then fetch 16'h0100.
//   6. PC at 16'hFFFF -> next instr_pc_po=16'h0000.
//      With FETCH_PERF_CNT_EN, 3 taken branches -> branch_count_po=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The optional performance counters are enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    localparam int          ADDR_W_DEF       = 16;
    localparam int          INSTR_W_DEF      = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    localparam int CNT_W        = 16;
    localparam int NUM_PERF_CNT = 2;
    localparam int PERF_FETCH   = 0;
    localparam int PERF_BRANCH  = 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating event counters for the fetch stage: accepted fetches and taken branches.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             fetch_inc,
    input  logic             branch_inc,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] branch_count
);

    logic [NUM_PERF_CNT-1:0]            inc;
    logic [NUM_PERF_CNT-1:0][CNT_W-1:0] count_bus;

    always_comb begin
        inc              = '0;
        inc[PERF_FETCH]  = fetch_inc;
        inc[PERF_BRANCH] = branch_inc;
    end

    generate
        for (genvar gi = 0; gi < NUM_PERF_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    count_reg <= '0;
                end else if (inc[gi]) begin
                    count_reg <= sat_inc(count_reg);
                end
            end

            assign count_bus[gi] = count_reg;
        end
    endgenerate

    assign fetch_count  = count_bus[PERF_FETCH];
    assign branch_count = count_bus[PERF_BRANCH];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request and hands it to decode.
// Define FETCH_PERF_CNT_EN to enable the fetch / taken-branch counters (otherwise tied to zero).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                INSTR_W      = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               clk_pi,
    input  logic               reset_pi,
    input  logic               branch_valid_pi,
    input  logic               is_branch_taken_pi,
    input  logic [ADDR_W-1:0]  branch_target_pi,
    input  logic               stall_pi,
    output logic               imem_req_po,
    output logic [ADDR_W-1:0]  imem_addr_po,
    input  logic               imem_ack_pi,
    input  logic [INSTR_W-1:0] imem_rdata_pi,
    output logic [INSTR_W-1:0] instr_po,
    output logic [ADDR_W-1:0]  instr_pc_po,
    output logic               instr_valid_po,
    output logic               flush_po,
    output logic [15:0]        fetch_count_po,
    output logic [15:0]        branch_count_po
);

    fetch_state_e       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W-1:0]  drain_addr_reg, drain_addr_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0]  instr_pc_reg, instr_pc_next;
    logic               instr_valid_reg, instr_valid_next;
    logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
    logic [ADDR_W-1:0]  skid_pc_reg, skid_pc_next;
    logic               flush_reg, flush_next;

    logic               branch_taken;
    logic               held;
    logic               req;
    logic [ADDR_W-1:0]  req_addr;

    assign branch_taken = branch_valid_pi & is_branch_taken_pi;
    assign held         = instr_valid_reg & stall_pi;
    assign req          = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
    // While draining, the abandoned request keeps its original address until acked.
    assign req_addr     = (state_reg == S_DRAIN) ? drain_addr_reg : pc_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        drain_addr_next  = drain_addr_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        skid_instr_next  = skid_instr_reg;
        skid_pc_next     = skid_pc_reg;
        flush_next       = 1'b0;

        if (branch_taken) begin
            pc_next          = branch_target_pi;
            flush_next       = 1'b1;
            instr_valid_next = 1'b0;
            if (req && !imem_ack_pi) begin
                state_next      = S_DRAIN;
                drain_addr_next = req_addr;
            end else begin
                state_next = S_FETCH;
            end
        end else begin
            case (state_reg)
                S_BOOT: begin
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack_pi) begin
                        pc_next = pc_reg + ADDR_W'(1);
                        if (held) begin
                            // Decode still owns the current word: park the new one.
                            skid_instr_next = imem_rdata_pi;
                            skid_pc_next    = pc_reg;
                            state_next      = S_HOLD;
                        end else begin
                            instr_next       = imem_rdata_pi;
                            instr_pc_next    = pc_reg;
                            instr_valid_next = 1'b1;
                        end
                    end else if (!stall_pi) begin
                        instr_valid_next = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_pi) begin
                        instr_next       = skid_instr_reg;
                        instr_pc_next    = skid_pc_reg;
                        instr_valid_next = 1'b1;
                        state_next       = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack_pi) begin
                        state_next = S_FETCH;
                    end
                end
                default: begin
                    state_next = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_reg       <= S_BOOT;
            pc_reg          <= RESET_VECTOR;
            drain_addr_reg  <= RESET_VECTOR;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            skid_instr_reg  <= '0;
            skid_pc_reg     <= '0;
            flush_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            drain_addr_reg  <= drain_addr_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            skid_instr_reg  <= skid_instr_next;
            skid_pc_reg     <= skid_pc_next;
            flush_reg       <= flush_next;
        end
    end

    assign imem_req_po    = req;
    assign imem_addr_po   = req_addr;
    assign instr_po       = instr_reg;
    assign instr_pc_po    = instr_pc_reg;
    assign instr_valid_po = instr_valid_reg;
    assign flush_po       = flush_reg;

`ifdef FETCH_PERF_CNT_EN
    logic accept_ack;

    // Acks in S_DRAIN or squashed by a same-cycle branch are not counted.
    assign accept_ack = (state_reg == S_FETCH) & imem_ack_pi & ~branch_taken;

    fetch_perf_counters u_perf (
        .clk          (clk_pi),
        .srst         (reset_pi),
        .fetch_inc    (accept_ack),
        .branch_inc   (branch_taken),
        .fetch_count  (fetch_count_po),
        .branch_count (branch_count_po)
    );
`else
    assign fetch_count_po  = 16'h0000;
    assign branch_count_po = 16'h0000;
`endif

endmodule
